// File: rtl/cpu_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the loader state encoding, field widths and the default memory depth.
package cpu_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam int unsigned DEPTH_DEFAULT = 64;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned WORD_W        = 16;
    localparam int unsigned CNT_W         = 16;

    // Largest word count a frame may announce for the default depth.
    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(DEPTH_DEFAULT);

    // The loader takes stream bytes only while a frame is in progress.
    function automatic logic in_frame(state_t s);
        return (s == ST_CNT_HI) || (s == ST_CNT_LO) || (s == ST_DATA_HI) ||
               (s == ST_DATA_LO) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/cpu_mem_loader.sv
// Loads the CPU's 16-bit unified memory from a framed byte stream and keeps
// the CPU stalled until a frame with a matching XOR checksum has been written.
module cpu_mem_loader
    import cpu_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          rx_data,
    input  logic                rx_vld,
    output logic                rx_rdy,
    output logic                we,
    output logic [ADDR_W-1:0]   d_addr,
    output logic [15:0]         wrt_data,
    output logic                cpu_hold,
    output logic                done,
    output logic                err
);

    localparam int unsigned      IDX_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEPTH);

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic [BYTE_W-1:0]     hi_reg, hi_next;
    logic [BYTE_W-1:0]     chk_reg, chk_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic                  we_reg, we_next;
    logic [ADDR_W-1:0]     d_addr_reg, d_addr_next;
    logic [WORD_W-1:0]     wrt_data_reg, wrt_data_next;
    logic                  done_reg, done_next;
    logic                  err_reg, err_next;
    logic                  hold_reg, hold_next;

    logic                  accept;
    logic [CNT_W-1:0]      cnt_full;
    logic [IDX_W-1:0]      idx_inc;

    assign rx_rdy   = in_frame(state_reg);
    assign accept   = rx_vld & rx_rdy;
    assign cnt_full = {count_reg[CNT_W-1:BYTE_W], rx_data};
    assign idx_inc  = idx_reg + IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            hi_reg       <= '0;
            chk_reg      <= '0;
            idx_reg      <= '0;
            we_reg       <= 1'b0;
            d_addr_reg   <= '0;
            wrt_data_reg <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            hold_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            hi_reg       <= hi_next;
            chk_reg      <= chk_next;
            idx_reg      <= idx_next;
            we_reg       <= we_next;
            d_addr_reg   <= d_addr_next;
            wrt_data_reg <= wrt_data_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            hold_reg     <= hold_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        hi_next       = hi_reg;
        chk_next      = chk_reg;
        idx_next      = idx_reg;
        we_next       = 1'b0;
        d_addr_next   = d_addr_reg;
        wrt_data_next = wrt_data_reg;
        done_next     = done_reg;
        err_next      = err_reg;
        hold_next     = hold_reg;

        // Every byte ahead of the checksum folds into the accumulator.
        if (accept && state_reg != ST_CHECK) begin
            chk_next = chk_reg ^ rx_data;
        end

        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next = ST_CNT_HI;
                    done_next  = 1'b0;
                    err_next   = 1'b0;
                    chk_next   = '0;
                    idx_next   = '0;
                    hold_next  = 1'b1;
                end
            end
            ST_CNT_HI: begin
                if (accept) begin
                    count_next = {rx_data, count_reg[BYTE_W-1:0]};
                    state_next = ST_CNT_LO;
                end
            end
            ST_CNT_LO: begin
                if (accept) begin
                    count_next = cnt_full;
                    if (cnt_full > MAX_CNT) begin
                        state_next = ST_ERROR;
                        err_next   = 1'b1;
                    end else if (cnt_full == '0) begin
                        state_next = ST_CHECK;
                    end else begin
                        state_next = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (accept) begin
                    hi_next    = rx_data;
                    state_next = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (accept) begin
                    we_next       = 1'b1;
                    d_addr_next   = ADDR_W'(idx_reg);
                    wrt_data_next = {hi_reg, rx_data};
                    idx_next      = idx_inc;
                    state_next    = (CNT_W'(idx_inc) == count_reg) ? ST_CHECK : ST_DATA_HI;
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    if (rx_data == chk_reg) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                        hold_next  = 1'b0;
                    end else begin
                        state_next = ST_ERROR;
                        err_next   = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign we       = we_reg;
    assign d_addr   = d_addr_reg;
    assign wrt_data = wrt_data_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign cpu_hold = hold_reg;

endmodule
